// File: rtl/stack_ctrl.sv
// LIFO controller in front of a single-port RAM (sync write, registered read).
// Push costs one write cycle; pop costs a read cycle plus a capture cycle.
module stack_ctrl #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] push_data,
    output logic       ready,
    output logic [7:0] pop_data,
    output logic       pop_valid,
    output logic [7:0] count,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       underflow,
    output logic [7:0] mem_data_in,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    input  logic [8:0] mem_data_out
);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StResp} state_e;

    state_e     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] pop_data_q, pop_data_d;
    logic       pop_valid_q, pop_valid_d;
    logic       overflow_q, overflow_d;
    logic       underflow_q, underflow_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_data_in_q, mem_data_in_d;
    logic       mem_we_q, mem_we_d;
    logic       full_w, empty_w;

    // The RAM's ninth bit carries nothing for this controller.
    logic unused_parity;
    assign unused_parity = mem_data_out[8];

    assign full_w  = (count_q == 8'(DEPTH));
    assign empty_w = (count_q == 8'd0);

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        pop_data_d    = pop_data_q;
        pop_valid_d   = 1'b0;
        overflow_d    = overflow_q;
        underflow_d   = underflow_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        mem_we_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Pop wins over a simultaneous push; the push is dropped.
                if (pop) begin
                    if (!empty_w) begin
                        state_d    = StRd;
                        mem_addr_d = count_q - 8'd1;
                    end else begin
                        underflow_d = 1'b1;
                    end
                end else if (push) begin
                    if (!full_w) begin
                        state_d       = StWr;
                        mem_addr_d    = count_q;
                        mem_data_in_d = push_data;
                        mem_we_d      = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            StWr: begin
                count_d = count_q + 8'd1;
                state_d = StIdle;
            end
            StRd: begin
                count_d = count_q - 8'd1;
                state_d = StResp;
            end
            StResp: begin
                pop_data_d  = mem_data_out[7:0];
                pop_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (clr) begin
            state_d     = StIdle;
            count_d     = 8'd0;
            mem_we_d    = 1'b0;
            pop_valid_d = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            count_q       <= 8'd0;
            pop_data_q    <= 8'd0;
            pop_valid_q   <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            mem_addr_q    <= 8'd0;
            mem_data_in_q <= 8'd0;
            mem_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            pop_data_q    <= pop_data_d;
            pop_valid_q   <= pop_valid_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_we_q      <= mem_we_d;
        end
    end

    assign ready       = (state_q == StIdle);
    assign full        = full_w;
    assign empty       = empty_w;
    assign count       = count_q;
    assign pop_data    = pop_data_q;
    assign pop_valid   = pop_valid_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_we      = mem_we_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: a RAM model, a queue-based stack reference and a
// monitor that matches RAM writes and popped bytes against expected queues.
module tb_stack_ctrl;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n, clr, push, pop;
    logic [7:0] push_data;
    logic       ready, pop_valid, full, empty, overflow, underflow, mem_we;
    logic [7:0] pop_data, count, mem_data_in, mem_addr;
    logic [8:0] mem_data_out;

    stack_ctrl #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .push        (push),
        .pop         (pop),
        .push_data   (push_data),
        .ready       (ready),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .underflow   (underflow),
        .mem_data_in (mem_data_in),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // RAM: synchronous write, registered read; bit 8 is random junk.
    logic [8:0] ram [256];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= {1'($urandom_range(0, 1)), mem_data_in};
        mem_data_out <= ram[mem_addr];
    end

    int total = 0;
    int bad = 0;
    int wecnt = 0;

    // Reference model: a plain queue used as a stack, plus sticky flags.
    logic [7:0]  stk[$];
    bit          m_ovf = 0, m_udf = 0;
    logic [7:0]  expq[$];
    logic [15:0] wq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pop_valid) begin
                chk("pop_valid with pending pop", 32'(pop_valid), 32'(expq.size() != 0));
                if (expq.size() != 0) chk("pop_data", pop_data, expq.pop_front());
            end
            if (mem_we) begin
                wecnt++;
                chk("write with pending push", 32'(mem_we), 32'(wq.size() != 0));
                if (wq.size() != 0) begin
                    logic [15:0] w;
                    w = wq.pop_front();
                    chk("wr addr", mem_addr, w[15:8]);
                    chk("wr data", mem_data_in, w[7:0]);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " count"}, count, stk.size());
        chk({tag, " full"}, full, stk.size() == DEPTH);
        chk({tag, " empty"}, empty, stk.size() == 0);
        chk({tag, " overflow"}, overflow, m_ovf);
        chk({tag, " underflow"}, underflow, m_udf);
    endtask

    task automatic issue(input bit p, input bit q, input logic [7:0] d);
        int  c;
        bit  rd;
        wait_ready();
        chk("ready before request", ready, 1);
        c  = stk.size();
        rd = 0;
        if (q) begin
            if (c > 0) begin
                expq.push_back(stk.pop_back());
                rd = 1;
            end else m_udf = 1;
        end else if (p) begin
            if (c < DEPTH) begin
                wq.push_back({c[7:0], d});
                stk.push_back(d);
            end else m_ovf = 1;
        end
        push = p; pop = q; push_data = d;
        @(posedge clk);
        #1;
        push = 0; pop = 0;
        if (rd) begin
            chk("rd addr", mem_addr, c - 1);
            chk("rd we", mem_we, 0);
        end
        wait_ready();
        #1;
        check_state("after op");
    endtask

    task automatic do_clr();
        wait_ready();
        clr = 1;
        @(posedge clk);
        #1;
        clr = 0;
        stk.delete();
        m_ovf = 0;
        m_udf = 0;
        check_state("after clr");
    endtask

    initial begin
        int snap;
        rst_n = 0; clr = 0; push = 0; pop = 0; push_data = 0;
        #3;
        chk("rst ready", ready, 1);
        chk("rst empty", empty, 1);
        chk("rst full", full, 0);
        chk("rst count", count, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst ovf", overflow, 0);
        chk("rst udf", underflow, 0);
        chk("rst pop_data", pop_data, 0);
        chk("rst mem_addr", mem_addr, 0);
        #4 rst_n = 1;
        @(posedge clk);
        #1;

        // LIFO order
        wecnt = 0;
        issue(1, 0, 8'h11); issue(1, 0, 8'h22); issue(1, 0, 8'h33);
        chk("lifo count3", count, 3);
        issue(0, 1, 0); issue(0, 1, 0); issue(0, 1, 0);
        chk("lifo we cycles", wecnt, 3);

        // Full and overflow
        do_clr();
        for (int i = 1; i <= 8; i++) issue(1, 0, 8'(i));
        chk("full flag", full, 1);
        snap = wecnt;
        issue(1, 0, 8'hFF);
        chk("overflow no write", wecnt, snap);
        chk("overflow set", overflow, 1);
        issue(0, 1, 0);

        // Underflow
        do_clr();
        issue(0, 1, 0);
        chk("underflow set", underflow, 1);
        chk("underflow no pop_valid", pop_valid, 0);
        do_clr();
        chk("underflow cleared", underflow, 0);

        // Simultaneous push and pop
        issue(1, 0, 8'hA0); issue(1, 0, 8'hB0);
        snap = wecnt;
        issue(1, 1, 8'hCC);
        chk("simul count", count, 1);
        chk("simul no write", wecnt, snap);

        // Reset mid-write
        wait_ready();
        push = 1; push_data = 8'h5A;
        @(posedge clk);
        #1;
        push = 0;
        chk("wr cycle we", mem_we, 1);
        rst_n = 0;
        #1;
        chk("reset drops we", mem_we, 0);
        wq.delete(); stk.delete(); m_ovf = 0; m_udf = 0;
        #1 rst_n = 1;
        @(posedge clk);
        #1;
        chk("post-reset count", count, 0);
        chk("post-reset ready", ready, 1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 9) issue(1, 0, 8'($urandom));
            else if (r < 16) issue(0, 1, 0);
            else if (r < 19) issue(1, 1, 8'($urandom));
            else do_clr();
        end

        repeat (4) @(posedge clk);
        #1;
        chk("pops outstanding", expq.size(), 0);
        chk("writes outstanding", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

LIFO (stack) controller that sits directly upstream of the single-port RAM and owns its data_in/addr/we inputs. It turns push/pop requests into RAM write and read cycles. It keeps the stack pointer, tracks full and empty, and records overflow and underflow errors. Popped bytes are taken from the low 8 bits of the RAM's 9-bit data_out.

## Interface
- DEPTH, 8, number of stack entries (1..255); RAM locations 0..DEPTH-1 are used.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear: empties the stack and clears the error flags.
- push  in  1  push request; sampled only while ready=1.
- pop  in  1  pop request; sampled only while ready=1.
- push_data  in  8  byte to push.
- ready  out  1  high when in IDLE and able to accept a request.
- pop_data  out  8  popped byte; holds its value until the next pop completes.
- pop_valid  out  1  one-cycle pulse when pop_data is updated.
- count  out  8  current number of entries.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow  out  1  sticky flag: a push was attempted while full.
- underflow  out  1  sticky flag: a pop was attempted while empty.
- mem_data_in  out  8  to RAM data_in.
- mem_addr  out  8  to RAM addr.
- mem_we  out  1  to RAM we; 1 = write.
- mem_data_out  in  9  from RAM data_out; bit 8 is ignored.

## Operation
- FSM states and transitions:
  - IDLE: accepts requests.
  - WR: RAM write in progress. Always returns to IDLE.
  - RD: RAM read issued. Always goes to RESP.
  - RESP: read data captured. Always returns to IDLE.
- ready = (state==IDLE). All outputs are registered except ready, full and empty, which are decoded from registers.
- Acceptance in IDLE, evaluated in this priority order:
  - pop & !empty: go to RD. Register mem_addr=count-1 and mem_we=0.
  - pop & empty: set underflow and stay in IDLE. No RAM access, no pop_valid.
  - push & !pop & !full: go to WR. Register mem_addr=count, mem_data_in=push_data, mem_we=1.
  - push & !pop & full: set overflow and stay in IDLE. mem_we stays 0.
  - push & pop together: pop is served and the push is dropped silently. The requester must re-issue it.
- WR: mem_we is high for exactly this one cycle. On leaving: count+1, mem_we=0.
- RD: on leaving, count-1.
- RESP: pop_data=mem_data_out[7:0] and pop_valid=1 for one cycle.
- Requests presented while ready=0 are ignored and are not flagged.
- mem_addr keeps its last value when idle. count never wraps: push is blocked at DEPTH and pop is blocked at 0.
- clr, in any state, takes priority over requests. It forces IDLE, count=0, mem_we=0, pop_valid=0 and clears both flags. pop_data is retained.
- Reset (rst_n=0) sets immediately, without waiting for a clock edge:
  - state=IDLE, count=0, pop_data=0, pop_valid=0, overflow=0, underflow=0;
  - mem_addr=0, mem_data_in=0, mem_we=0.
  - Resulting decoded outputs: ready=1, empty=1, full=0.
- A reset asserted during WR deasserts mem_we at once, and the write may not complete.

## Timing
- The RAM model is a synchronous write on clk when we=1, with a registered read whose data_out is valid one cycle after addr.
- Push accepted at edge N:
  - mem_we=1 during cycle N+1;
  - the RAM writes at edge N+1;
  - count, full and ready update after edge N+1.
  - Push throughput is 1 per 2 cycles.
- Pop accepted at edge N:
  - mem_addr is driven during cycle N+1;
  - count decrements at edge N+1;
  - RAM data is valid during cycle N+2 (RESP);
  - pop_data and pop_valid=1 appear after edge N+2, with ready=1 in the same cycle.
  - Pop throughput is 1 per 3 cycles.
- Error flags set at the edge that samples the illegal request.

## Test plan
- Reset: with rst_n=0 held mid-cycle, check ready=1, empty=1, count=0, mem_we=0, overflow=underflow=0 without any clock edge.
- LIFO order: push 0x11, 0x22, 0x33, then pop three times. pop_data must read 0x33, 0x22, 0x11, with count going 3, 2, 1, 0. mem_addr must be 0, 1, 2 for the writes and 2, 1, 0 for the reads, and mem_we must be high exactly 3 cycles.
- Full and overflow (DEPTH=8): push 0x01..0x08, check full=1 and count=8. A 9th push of 0xFF must set overflow=1 with no mem_we pulse, and the next pop must return 0x08.
- Underflow: pop on an empty stack must set underflow=1 with pop_valid held 0 and count held 0. clr must then clear the flag.
- Simultaneous requests: with count=2 holding 0xA0, 0xB0, assert push=1 (0xCC) and pop=1 together. The result must be pop_data=0xB0 and count=1, with no write cycle.
- Reset mid-write: assert rst_n=0 during the WR cycle. mem_we must fall immediately, and after release count=0 and ready=1.
